// File: rtl/uart_comm_pkg.sv
// Shared state encodings and constants for the UART command/telemetry controller.
package uart_comm_pkg;

    typedef enum logic [1:0] {
        RX_B0 = 2'd0,
        RX_B1 = 2'd1,
        RX_B2 = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_RESP = 2'd1,
        TX_TLM  = 2'd2,
        TX_WAIT = 2'd3
    } tx_state_t;

    localparam int FRAME_BYTES      = 3;
    localparam int FRAME_TO_DEFAULT = 1_000_000;

endpackage

// File: rtl/uart_frame_rx.sv
// Assembles 3-byte command frames from the UART receive path and holds the
// last complete frame until a new one finishes; partial frames time out.
module uart_frame_rx
    import uart_comm_pkg::*;
#(
    parameter int FRAME_TO = FRAME_TO_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    input  logic        clr_cmd_rdy,
    output logic        cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        frame_err
);

    localparam int               CNT_W   = $clog2(FRAME_TO + 1);
    localparam int               SHADOW_W = 8 * (FRAME_BYTES - 1);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(FRAME_TO);

    rx_state_t             state_q, state_d;
    logic [SHADOW_W-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [15:0]           data_q, data_d;
    logic                  cmd_rdy_q, cmd_rdy_d;
    logic                  frame_err_q, frame_err_d;

    // Every byte presented is taken in the same cycle it appears.
    assign clr_rx_rdy = rx_rdy;

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        cmd_rdy_d   = cmd_rdy_q & ~clr_cmd_rdy;
        frame_err_d = 1'b0;

        if (rx_rdy) begin
            cnt_d = '0;
            case (state_q)
                RX_B0: begin
                    shadow_d[SHADOW_W-1 -: 8] = rx_data;
                    cmd_rdy_d                 = 1'b0;
                    state_d                   = RX_B1;
                end
                RX_B1: begin
                    shadow_d[7:0] = rx_data;
                    state_d       = RX_B2;
                end
                RX_B2: begin
                    cmd_d     = shadow_q[SHADOW_W-1 -: 8];
                    data_d    = {shadow_q[7:0], rx_data};
                    cmd_rdy_d = 1'b1;
                    state_d   = RX_B0;
                end
                default: state_d = RX_B0;
            endcase
        end else if (state_q != RX_B0) begin
            // A byte arriving on the expiry cycle still belongs to the frame.
            if (cnt_q == TO_VAL) begin
                state_d     = RX_B0;
                shadow_d    = '0;
                cnt_d       = '0;
                frame_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RX_B0;
            shadow_q    <= '0;
            cnt_q       <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            cmd_rdy_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            cmd_rdy_q   <= cmd_rdy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign cmd_rdy   = cmd_rdy_q;
    assign cmd       = cmd_q;
    assign data      = data_q;
    assign frame_err = frame_err_q;

endmodule

// File: rtl/uart_comm_ctrl.sv
// UART command/telemetry controller: frame receiver plus an arbiter that shares
// the transmitter between 1-byte responses and non-preemptible telemetry packets.
module uart_comm_ctrl
    import uart_comm_pkg::*;
#(
    parameter int TLM_BYTES = 4,
    parameter int FRAME_TO  = FRAME_TO_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_rdy,
    input  logic [7:0]             rx_data,
    output logic                   clr_rx_rdy,
    output logic                   trmt,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic                   cmd_rdy,
    output logic [7:0]             cmd,
    output logic [15:0]            data,
    input  logic                   clr_cmd_rdy,
    output logic                   frame_err,
    input  logic                   send_resp,
    input  logic [7:0]             resp,
    output logic                   resp_sent,
    input  logic                   tlm_req,
    input  logic [8*TLM_BYTES-1:0] tlm_pkt,
    output logic                   tlm_busy,
    output logic                   tlm_drop
);

    localparam int PKT_W  = 8 * TLM_BYTES;
    localparam int LEFT_W = $clog2(TLM_BYTES + 1);

    uart_frame_rx #(
        .FRAME_TO (FRAME_TO)
    ) u_frame_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .data        (data),
        .frame_err   (frame_err)
    );

    tx_state_t          tx_state_q, tx_state_d;
    logic               resp_pend_q, resp_pend_d;
    logic [7:0]         resp_q, resp_d;
    logic               tlm_busy_q, tlm_busy_d;
    logic [PKT_W-1:0]   tlm_sh_q, tlm_sh_d;
    logic [LEFT_W-1:0]  tlm_left_q, tlm_left_d;
    logic               cur_resp_q, cur_resp_d;
    logic               trmt_q, trmt_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               resp_sent_q, resp_sent_d;
    logic               tlm_drop_q, tlm_drop_d;
    logic               tlm_accept;

    assign tlm_accept = tlm_req & ~tlm_busy_q;

    always_comb begin
        tx_state_d  = tx_state_q;
        resp_pend_d = resp_pend_q;
        resp_d      = resp_q;
        tlm_busy_d  = tlm_busy_q;
        tlm_sh_d    = tlm_sh_q;
        tlm_left_d  = tlm_left_q;
        cur_resp_d  = cur_resp_q;
        trmt_d      = 1'b0;
        tx_data_d   = tx_data_q;
        resp_sent_d = 1'b0;
        tlm_drop_d  = tlm_req & tlm_busy_q;

        if (send_resp) begin
            resp_pend_d = 1'b1;
            resp_d      = resp;
        end
        if (tlm_accept) begin
            tlm_busy_d = 1'b1;
            tlm_sh_d   = tlm_pkt;
            tlm_left_d = LEFT_W'(TLM_BYTES);
        end

        case (tx_state_q)
            // Requests arriving this cycle are seen directly so a start costs one cycle.
            TX_IDLE: begin
                if (resp_pend_q || send_resp) begin
                    tx_state_d = TX_RESP;
                end else if (tlm_busy_q || tlm_accept) begin
                    tx_state_d = TX_TLM;
                end
            end
            TX_RESP: begin
                trmt_d     = 1'b1;
                tx_data_d  = send_resp ? resp : resp_q;
                cur_resp_d = 1'b1;
                tx_state_d = TX_WAIT;
            end
            TX_TLM: begin
                trmt_d     = 1'b1;
                tx_data_d  = tlm_sh_q[PKT_W-1 -: 8];
                tlm_sh_d   = tlm_sh_q << 8;
                tlm_left_d = tlm_left_q - 1'b1;
                cur_resp_d = 1'b0;
                tx_state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (tx_done) begin
                    if (cur_resp_q) begin
                        // A fresh request in the completion cycle stays pending.
                        resp_pend_d = send_resp;
                        resp_sent_d = 1'b1;
                        tx_state_d  = TX_IDLE;
                    end else if (tlm_left_q != '0) begin
                        tx_state_d = TX_TLM;
                    end else begin
                        tlm_busy_d = 1'b0;
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= TX_IDLE;
            resp_pend_q <= 1'b0;
            resp_q      <= '0;
            tlm_busy_q  <= 1'b0;
            tlm_sh_q    <= '0;
            tlm_left_q  <= '0;
            cur_resp_q  <= 1'b0;
            trmt_q      <= 1'b0;
            tx_data_q   <= '0;
            resp_sent_q <= 1'b0;
            tlm_drop_q  <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            resp_pend_q <= resp_pend_d;
            resp_q      <= resp_d;
            tlm_busy_q  <= tlm_busy_d;
            tlm_sh_q    <= tlm_sh_d;
            tlm_left_q  <= tlm_left_d;
            cur_resp_q  <= cur_resp_d;
            trmt_q      <= trmt_d;
            tx_data_q   <= tx_data_d;
            resp_sent_q <= resp_sent_d;
            tlm_drop_q  <= tlm_drop_d;
        end
    end

    assign trmt      = trmt_q;
    assign tx_data   = tx_data_q;
    assign resp_sent = resp_sent_q;
    assign tlm_busy  = tlm_busy_q;
    assign tlm_drop  = tlm_drop_q;

endmodule

// File: tb/tb_uart_comm_ctrl.sv
// Randomised bench for uart_comm_ctrl with a transaction-level reference model
// and directed frame, arbitration, drop and reset scenarios.
`timescale 1ns/1ps
module tb_uart_comm_ctrl;

    localparam int TLM_BYTES = 4;
    localparam int FRAME_TO  = 20;
    localparam int PKT_W     = 8 * TLM_BYTES;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             rx_rdy;
    logic [7:0]       rx_data;
    logic             clr_rx_rdy;
    logic             trmt;
    logic [7:0]       tx_data;
    logic             tx_done;
    logic             cmd_rdy;
    logic [7:0]       cmd;
    logic [15:0]      data;
    logic             clr_cmd_rdy;
    logic             frame_err;
    logic             send_resp;
    logic [7:0]       resp;
    logic             resp_sent;
    logic             tlm_req;
    logic [PKT_W-1:0] tlm_pkt;
    logic             tlm_busy;
    logic             tlm_drop;

    int tests = 0;
    int fails = 0;

    uart_comm_ctrl #(
        .TLM_BYTES (TLM_BYTES),
        .FRAME_TO  (FRAME_TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .data        (data),
        .clr_cmd_rdy (clr_cmd_rdy),
        .frame_err   (frame_err),
        .send_resp   (send_resp),
        .resp        (resp),
        .resp_sent   (resp_sent),
        .tlm_req     (tlm_req),
        .tlm_pkt     (tlm_pkt),
        .tlm_busy    (tlm_busy),
        .tlm_drop    (tlm_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int          m_have;
    logic [7:0]  m_sh0, m_sh1;
    int          m_idle;
    logic [7:0]  m_cmd;
    logic [15:0] m_data;
    logic        m_cmd_rdy, m_ferr;

    logic        m_resp_pend;
    logic [7:0]  m_resp_val;
    logic        m_tlm_busy;
    logic [7:0]  m_tlm_q[$];
    int          m_inflight;    // 0 none, 1 response byte, 2 telemetry byte
    int          m_kind;
    longint      m_launch;
    logic        m_free;
    logic        m_trmt, m_rsent, m_drop;
    logic [7:0]  m_txd;
    longint      ecount;

    task automatic model_reset();
        m_have = 0; m_sh0 = '0; m_sh1 = '0; m_idle = 0;
        m_cmd = '0; m_data = '0; m_cmd_rdy = 1'b0; m_ferr = 1'b0;
        m_resp_pend = 1'b0; m_resp_val = '0; m_tlm_busy = 1'b0; m_tlm_q = {};
        m_inflight = 0; m_kind = 0; m_launch = -1; m_free = 1'b1;
        m_trmt = 1'b0; m_rsent = 1'b0; m_drop = 1'b0; m_txd = '0;
        ecount = 0;
    endtask

    task automatic model_step();
        logic free_now;
        ecount++;
        // receive: bytes fill a 3-byte frame; too long a silence discards it
        m_ferr = 1'b0;
        if (clr_cmd_rdy) m_cmd_rdy = 1'b0;
        if (rx_rdy) begin
            m_idle = 0;
            if (m_have == 0) begin
                m_sh0 = rx_data; m_cmd_rdy = 1'b0; m_have = 1;
            end else if (m_have == 1) begin
                m_sh1 = rx_data; m_have = 2;
            end else begin
                m_cmd = m_sh0; m_data = {m_sh1, rx_data}; m_cmd_rdy = 1'b1; m_have = 0;
            end
        end else if (m_have != 0) begin
            m_idle++;
            if (m_idle > FRAME_TO) begin
                m_have = 0; m_idle = 0; m_ferr = 1'b1;
            end
        end
        // transmit: requests, then launch / completion of the channel
        m_trmt = 1'b0; m_rsent = 1'b0; m_drop = 1'b0;
        free_now = m_free;
        if (send_resp) begin
            m_resp_pend = 1'b1; m_resp_val = resp;
        end
        if (tlm_req) begin
            if (m_tlm_busy) m_drop = 1'b1;
            else begin
                m_tlm_busy = 1'b1;
                m_tlm_q = {};
                for (int i = TLM_BYTES - 1; i >= 0; i--) m_tlm_q.push_back(tlm_pkt[8*i +: 8]);
            end
        end
        if (free_now) begin
            if (m_resp_pend) begin
                m_kind = 1; m_launch = ecount + 1; m_free = 1'b0;
            end else if (m_tlm_busy) begin
                m_kind = 2; m_launch = ecount + 1; m_free = 1'b0;
            end
        end else if (m_launch == ecount) begin
            m_trmt = 1'b1;
            if (m_kind == 1) m_txd = m_resp_val;
            else m_txd = m_tlm_q.pop_front();
            m_inflight = m_kind;
            m_launch = -1;
        end else if (m_inflight != 0 && tx_done) begin
            if (m_inflight == 1) begin
                if (!send_resp) m_resp_pend = 1'b0;
                m_rsent = 1'b1; m_free = 1'b1;
            end else if (m_tlm_q.size() != 0) begin
                m_kind = 2; m_launch = ecount + 1;
            end else begin
                m_tlm_busy = 1'b0; m_free = 1'b1;
            end
            m_inflight = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // ---------------- per-cycle compare and transmit log ----------------
    logic [7:0] tx_log[$];
    int trmt_cnt = 0, rsent_cnt = 0, drop_cnt = 0, ferr_cnt = 0;

    always @(posedge clk) begin
        #2;
        chk("clr_rx_rdy", 64'(clr_rx_rdy), 64'(rx_rdy));
        chk("cmd_rdy",    64'(cmd_rdy),    64'(m_cmd_rdy));
        chk("cmd",        64'(cmd),        64'(m_cmd));
        chk("data",       64'(data),       64'(m_data));
        chk("frame_err",  64'(frame_err),  64'(m_ferr));
        chk("trmt",       64'(trmt),       64'(m_trmt));
        chk("tx_data",    64'(tx_data),    64'(m_txd));
        chk("resp_sent",  64'(resp_sent),  64'(m_rsent));
        chk("tlm_busy",   64'(tlm_busy),   64'(m_tlm_busy));
        chk("tlm_drop",   64'(tlm_drop),   64'(m_drop));
        if (trmt === 1'b1) begin
            tx_log.push_back(tx_data);
            trmt_cnt++;
        end
        if (resp_sent === 1'b1) rsent_cnt++;
        if (tlm_drop === 1'b1) drop_cnt++;
        if (frame_err === 1'b1) ferr_cnt++;
    end

    // ---------------- UART transmitter stand-in ----------------
    initial begin
        int cnt;
        cnt = 0;
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (trmt === 1'b1) begin
                tx_done = 1'b0;
                cnt = $urandom_range(2, 8);
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) tx_done = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(negedge clk);
        rx_rdy = 1'b0; send_resp = 1'b0; tlm_req = 1'b0; clr_cmd_rdy = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        next_cycle();
        rx_rdy = 1'b1; rx_data = b;
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k;
        k = 0;
        while (tx_log.size() < n && k < budget) begin
            next_cycle();
            k++;
        end
        if (tx_log.size() < n) begin
            tests++; fails++;
            $display("FAIL wait_tx bytes=%0d required=%0d", tx_log.size(), n);
        end
    endtask

    task automatic check_log(input string tag, input logic [63:0] seq, input int n);
        chk({tag, "_len"}, 64'(tx_log.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < tx_log.size())
                chk($sformatf("%s_b%0d", tag, i), 64'(tx_log[i]), 64'(seq[8*(n-1-i) +: 8]));
        end
    endtask

    initial begin
        int r0, d0, f0, t0, rate;
        rst_n = 1'b0; rx_rdy = 1'b0; rx_data = '0; clr_cmd_rdy = 1'b0;
        send_resp = 1'b0; resp = '0; tlm_req = 1'b0; tlm_pkt = '0;
        repeat (3) next_cycle();
        chk("reset_outputs", 64'({trmt, tx_data, cmd_rdy, cmd, data, frame_err,
                                  resp_sent, tlm_busy, tlm_drop, clr_rx_rdy}), 64'(0));
        rst_n = 1'b1;
        repeat (2) next_cycle();

        // complete frame, then consumer acknowledge
        send_byte(8'h05); send_byte(8'h12); send_byte(8'h34);
        next_cycle();
        chk("frame1_cmd", 64'(cmd), 64'h05);
        chk("frame1_data", 64'(data), 64'h1234);
        chk("frame1_rdy", 64'(cmd_rdy), 64'd1);
        clr_cmd_rdy = 1'b1;
        next_cycle();
        chk("clr_cmd_rdy", 64'(cmd_rdy), 64'd0);

        // partial frame timeout leaves held frame untouched
        f0 = ferr_cnt;
        send_byte(8'h05); send_byte(8'h12);
        repeat (FRAME_TO + 3) next_cycle();
        chk("timeout_ferr", 64'(ferr_cnt - f0), 64'd1);
        chk("timeout_rdy", 64'(cmd_rdy), 64'd0);
        chk("timeout_data", 64'(data), 64'h1234);
        send_byte(8'h07); send_byte(8'hAB); send_byte(8'hCD);
        next_cycle();
        chk("frame2_cmd", 64'(cmd), 64'h07);
        chk("frame2_data", 64'(data), 64'hABCD);
        chk("frame2_rdy", 64'(cmd_rdy), 64'd1);

        // response queued mid-packet waits; latest response byte wins
        tx_log = {}; r0 = rsent_cnt;
        next_cycle();
        tlm_req = 1'b1; tlm_pkt = 32'h11223344;
        wait_tx(2, 200);
        next_cycle();
        send_resp = 1'b1; resp = 8'h5A;
        next_cycle();
        send_resp = 1'b1; resp = 8'hA5;
        wait_tx(5, 400);
        repeat (15) next_cycle();
        check_log("pkt_then_resp", 64'h11223344A5, 5);
        chk("resp_sent_once", 64'(rsent_cnt - r0), 64'd1);
        chk("tlm_busy_done", 64'(tlm_busy), 64'd0);

        // simultaneous requests: response first
        tx_log = {};
        next_cycle();
        send_resp = 1'b1; resp = 8'hA5; tlm_req = 1'b1; tlm_pkt = 32'h55667788;
        wait_tx(5, 400);
        repeat (15) next_cycle();
        check_log("resp_first", 64'hA555667788, 5);

        // request while busy is dropped, first packet unaltered
        tx_log = {}; d0 = drop_cnt;
        next_cycle();
        tlm_req = 1'b1; tlm_pkt = 32'h01020304;
        next_cycle();
        next_cycle();
        tlm_req = 1'b1; tlm_pkt = 32'hDEADBEEF;
        wait_tx(4, 400);
        repeat (15) next_cycle();
        chk("tlm_drop_once", 64'(drop_cnt - d0), 64'd1);
        check_log("no_overwrite", 64'h01020304, 4);

        // reset in the middle of a packet
        tx_log = {};
        next_cycle();
        tlm_req = 1'b1; tlm_pkt = 32'hCAFEF00D;
        wait_tx(2, 200);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", 64'({trmt, tx_data, cmd_rdy, cmd, data, frame_err,
                                   resp_sent, tlm_busy, tlm_drop, clr_rx_rdy}), 64'(0));
        t0 = trmt_cnt;
        repeat (3) next_cycle();
        rst_n = 1'b1;
        repeat (40) next_cycle();
        chk("midrst_no_trmt", 64'(trmt_cnt - t0), 64'd0);

        // randomised traffic, alternating dense and sparse receive phases
        for (int c = 0; c < 4000; c++) begin
            next_cycle();
            rate = ((c / 500) % 2 == 1) ? 3 : 30;
            if ($urandom_range(0, rate) == 0) begin
                rx_rdy = 1'b1; rx_data = 8'($urandom);
            end
            if ($urandom_range(0, 40) == 0) clr_cmd_rdy = 1'b1;
            if ($urandom_range(0, 60) == 0) begin
                send_resp = 1'b1; resp = 8'($urandom);
            end
            if ($urandom_range(0, 50) == 0) begin
                tlm_req = 1'b1; tlm_pkt = PKT_W'($urandom);
            end
        end
        repeat (40) next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
